// File: rtl/sfp_receiver_pkg.sv
// Shared constants and the per-output match rule for the SFP event receiver.
package sfp_receiver_pkg;

  localparam logic [7:0] K28_5       = 8'hBC;
  localparam logic [7:0] HEARTBEAT   = 8'h7A;
  localparam logic [7:0] RESET_PRESC = 8'h7B;
  localparam logic [7:0] EVENT_CODE  = 8'h7C;
  localparam logic [7:0] RESET_EVENT = 8'h7D;
  localparam logic [7:0] SECONDS_0   = 8'h70;
  localparam logic [7:0] SECONDS_1   = 8'h71;

  localparam int CFG_MODE_BIT = 8;
  localparam int CFG_W        = 9;
  localparam int MAX_EVENTS   = 4;

  // Code mode: exact data-byte match, code 0x00 (idle filler) never matches.
  // Dbus mode: any masked dbus bit set; an all-zero mask never matches.
  function automatic logic event_match(input logic [CFG_W-1:0] cfg,
                                       input logic [15:0]      rxdata,
                                       input logic [1:0]       charisk);
    if (cfg[CFG_MODE_BIT])
      return (|(rxdata[15:8] & cfg[7:0])) && !charisk[1];
    else
      return (rxdata[7:0] == cfg[7:0]) && !charisk[0] && (cfg[7:0] != 8'h00);
  endfunction

endpackage

// File: rtl/sfp_link_monitor.sv
// Symbol-error register, link qualification counter and sticky loss-of-lock.
module sfp_link_monitor #(
  parameter int LINK_OK_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] rxdisperr_i,
  input  logic [1:0] rxnotintable_i,
  output logic       rx_link_ok_o,
  output logic       loss_lock_o,
  output logic       rx_error_o
);

  localparam int               CNT_W   = $clog2(LINK_OK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINK_OK_CYCLES);

  logic             w_err;
  logic             w_link_ok;
  logic [CNT_W-1:0] r_cnt;
  logic             r_error;
  logic             r_loss_lock;

  assign w_err     = |(rxdisperr_i | rxnotintable_i);
  assign w_link_ok = (r_cnt == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt       <= '0;
      r_error     <= 1'b0;
      r_loss_lock <= 1'b0;
    end else begin
      r_error <= w_err;
      if (w_err)
        r_cnt <= '0;
      else if (!w_link_ok)
        r_cnt <= r_cnt + CNT_W'(1);
      // Falling edge of link_ok coincides with an error while qualified.
      if (w_err && w_link_ok)
        r_loss_lock <= 1'b1;
    end
  end

  assign rx_link_ok_o = w_link_ok;
  assign loss_lock_o  = r_loss_lock;
  assign rx_error_o   = r_error;

endmodule

// File: rtl/sfp_receiver.sv
// Receive-side event decoder: per-output code/dbus matching plus link health.
module sfp_receiver
  import sfp_receiver_pkg::*;
#(
  parameter int events         = 4,
  parameter int LINK_OK_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] rxdata_i,
  input  logic [1:0]  rxcharisk_i,
  input  logic [1:0]  rxdisperr_i,
  input  logic [1:0]  rxnotintable_i,
  input  logic [31:0] EVENT1,
  input  logic [31:0] EVENT2,
  input  logic [31:0] EVENT3,
  input  logic [31:0] EVENT4,
  input  logic        EVENT1_WSTB,
  input  logic        EVENT2_WSTB,
  input  logic        EVENT3_WSTB,
  input  logic        EVENT4_WSTB,
  output logic        rx_link_ok_o,
  output logic        loss_lock_o,
  output logic        rx_error_o,
  output logic        bit1_o,
  output logic        bit2_o,
  output logic        bit3_o,
  output logic        bit4_o
);

  logic [CFG_W-1:0]      w_event [MAX_EVENTS];
  logic [MAX_EVENTS-1:0] w_wstb;
  logic [MAX_EVENTS-1:0] w_bit;
  logic                  w_unused;

  assign w_event[0] = EVENT1[CFG_W-1:0];
  assign w_event[1] = EVENT2[CFG_W-1:0];
  assign w_event[2] = EVENT3[CFG_W-1:0];
  assign w_event[3] = EVENT4[CFG_W-1:0];
  assign w_wstb     = {EVENT4_WSTB, EVENT3_WSTB, EVENT2_WSTB, EVENT1_WSTB};
  assign w_unused   = ^{EVENT1[31:CFG_W], EVENT2[31:CFG_W],
                        EVENT3[31:CFG_W], EVENT4[31:CFG_W]};

  for (genvar n = 0; n < MAX_EVENTS; n++) begin : g_event
    if (n < events) begin : g_on
      logic [CFG_W-1:0] r_cfg;
      logic             r_bit;

      // The match uses the pre-edge cfg, so a write on this edge only
      // affects data sampled from the next edge onward.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          r_cfg <= '0;
          r_bit <= 1'b0;
        end else begin
          if (w_wstb[n])
            r_cfg <= w_event[n];
          r_bit <= event_match(r_cfg, rxdata_i, rxcharisk_i);
        end
      end

      assign w_bit[n] = r_bit;
    end else begin : g_off
      assign w_bit[n] = 1'b0;
    end
  end

  assign bit1_o = w_bit[0];
  assign bit2_o = w_bit[1];
  assign bit3_o = w_bit[2];
  assign bit4_o = w_bit[3];

  sfp_link_monitor #(
    .LINK_OK_CYCLES (LINK_OK_CYCLES)
  ) u_link_monitor (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .rxdisperr_i    (rxdisperr_i),
    .rxnotintable_i (rxnotintable_i),
    .rx_link_ok_o   (rx_link_ok_o),
    .loss_lock_o    (loss_lock_o),
    .rx_error_o     (rx_error_o)
  );

endmodule

// File: tb/tb_sfp_receiver.sv
// Directed bench for sfp_receiver with a queue scoreboard and a link-counter model.
module tb_sfp_receiver;
  import sfp_receiver_pkg::*;

  localparam int LINK = 4096;

  typedef struct packed {
    logic [3:0] bits;
    logic       err;
    logic       ok;
    logic       loss;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rxdata = '0;
  logic [1:0]  charisk = '0;
  logic [1:0]  disperr = '0;
  logic [1:0]  notintable = '0;
  logic [31:0] ev [4] = '{default: '0};
  logic [3:0]  wstb = '0;
  logic        link_ok, loss_lock, rx_error;
  logic        bit1, bit2, bit3, bit4;

  obs_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  logic m_loss = 1'b0;

  always #5 clk = ~clk;

  sfp_receiver #(
    .events         (4),
    .LINK_OK_CYCLES (LINK)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .rxdata_i       (rxdata),
    .rxcharisk_i    (charisk),
    .rxdisperr_i    (disperr),
    .rxnotintable_i (notintable),
    .EVENT1         (ev[0]),
    .EVENT2         (ev[1]),
    .EVENT3         (ev[2]),
    .EVENT4         (ev[3]),
    .EVENT1_WSTB    (wstb[0]),
    .EVENT2_WSTB    (wstb[1]),
    .EVENT3_WSTB    (wstb[2]),
    .EVENT4_WSTB    (wstb[3]),
    .rx_link_ok_o   (link_ok),
    .loss_lock_o    (loss_lock),
    .rx_error_o     (rx_error),
    .bit1_o         (bit1),
    .bit2_o         (bit2),
    .bit3_o         (bit3),
    .bit4_o         (bit4)
  );

  task automatic wr(input int n, input logic [31:0] val);
    ev[n]   = val;
    wstb[n] = 1'b1;
  endtask

  // One clock of stimulus; eb is the hand-derived bit pattern expected after this edge.
  task automatic step(input string tag, input logic [15:0] d, input logic [1:0] k,
                      input logic [1:0] de, input logic [1:0] nt, input logic [3:0] eb);
    obs_t e, o;
    logic err_m;
    @(negedge clk);
    rxdata = d; charisk = k; disperr = de; notintable = nt;
    err_m = |(de | nt);
    if (reset) begin
      m_cnt  = 0;
      m_loss = 1'b0;
      e      = '{bits: 4'b0000, err: 1'b0, ok: 1'b0, loss: 1'b0};
    end else begin
      if (err_m && m_cnt == LINK) m_loss = 1'b1;
      if (err_m) m_cnt = 0;
      else if (m_cnt < LINK) m_cnt++;
      e = '{bits: eb, err: err_m, ok: (m_cnt == LINK), loss: m_loss};
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    o = '{bits: {bit4, bit3, bit2, bit1}, err: rx_error, ok: link_ok, loss: loss_lock};
    e = q.pop_front();
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed bits=%b err=%b ok=%b loss=%b, expected bits=%b err=%b ok=%b loss=%b",
             tag, o.bits, o.err, o.ok, o.loss, e.bits, e.err, e.ok, e.loss);
    end
    wstb = '0;
  endtask

  initial begin
    // Reset state
    step("reset0", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("reset1", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    reset = 1'b0;

    // Idle/comma with reset cfg, then zero code and zero dbus mask
    for (int i = 0; i < 6; i++)
      step("idle_rst_cfg", (i % 2 != 0) ? {8'h00, K28_5} : 16'h0000,
           (i % 2 != 0) ? 2'b01 : 2'b00, 2'b00, 2'b00, 4'b0000);
    step("comma_k0", {8'hFF, K28_5}, 2'b00, 2'b00, 2'b00, 4'b0000);
    wr(0, 32'h0000_0000);
    wr(1, 32'h0000_0100);
    step("wr_zero", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("zero_code", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("zero_mask", {8'hFF, K28_5}, 2'b00, 2'b00, 2'b00, 4'b0000);

    // Error before first qualification must not set loss_lock
    step("early_err", 16'h0000, 2'b00, 2'b00, 2'b10, 4'b0000);

    // Code mode
    wr(0, 32'h0000_007C);
    step("wr_ev1", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("code_hit", {8'h00, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b0001);
    step("code_after", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("code_k", {8'h00, EVENT_CODE}, 2'b01, 2'b00, 2'b00, 4'b0000);
    step("code_k_after", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);

    // Strobe edge uses old cfg; new cfg applies from next edge
    wr(0, 32'hFFFF_FE71);
    step("strobe_old", {8'h00, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b0001);
    step("strobe_new", {8'h00, SECONDS_1}, 2'b00, 2'b00, 2'b00, 4'b0001);
    step("strobe_stale", {8'h00, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b0000);

    // All four channels, written on successive cycles
    wr(0, 32'h0000_007C);
    step("wr1", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    wr(1, 32'h0000_007B);
    step("wr2", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    wr(2, 32'h0000_007A);
    step("wr3", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    wr(3, 32'h0000_0180);
    step("wr4", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("presc", {8'h00, RESET_PRESC}, 2'b00, 2'b00, 2'b00, 4'b0010);
    step("heartbeat", {8'h00, HEARTBEAT}, 2'b00, 2'b00, 2'b00, 4'b0100);
    step("sec0_none", {8'h00, SECONDS_0}, 2'b00, 2'b00, 2'b00, 4'b0000);

    // Dbus mode
    for (int i = 0; i < 3; i++)
      step("dbus_run", 16'h8000, 2'b00, 2'b00, 2'b00, 4'b1000);
    step("dbus_7f", 16'h7F00, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("dbus_k", 16'h8000, 2'b10, 2'b00, 2'b00, 4'b0000);
    step("dbus_code", {8'h80, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b1001);

    // Special code matched like any other
    wr(2, 32'({1'b0, RESET_EVENT}));
    step("wr_7d", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("code_7d", {8'h00, RESET_EVENT}, 2'b00, 2'b00, 2'b00, 4'b0100);

    // Link qualification, single error, relock
    for (int i = 0; i < LINK + 4; i++)
      step("link_wait", (i % 2 != 0) ? {8'h00, K28_5} : 16'h0000,
           (i % 2 != 0) ? 2'b01 : 2'b00, 2'b00, 2'b00, 4'b0000);
    step("disperr", 16'h0000, 2'b00, 2'b01, 2'b00, 4'b0000);
    step("post_err", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);
    for (int i = 0; i < LINK + 2; i++)
      step("relock", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);

    // Reset during continuous match
    step("pre_rst_a", {8'h00, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b0001);
    step("pre_rst_b", {8'h00, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b0001);
    reset = 1'b1;
    step("mid_reset", {8'h00, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b0000);
    reset = 1'b0;
    step("cfg_cleared", {8'h00, EVENT_CODE}, 2'b00, 2'b00, 2'b00, 4'b0000);
    step("dbus_cleared", 16'hFF00, 2'b00, 2'b00, 2'b00, 4'b0000);
    for (int i = 0; i < LINK + 1; i++)
      step("restart_cnt", 16'h0000, 2'b00, 2'b00, 2'b00, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
